// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/operand/memory/execute sequencer for the 6502 core
module cpu_sequencer #(
  parameter logic [15:0] RESET_VECTOR = 16'hFFFC
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rdy,
  input  logic [7:0]  data_in,
  input  logic [1:0]  addr_mode,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  output logic [15:0] addr,
  output logic        rd_en,
  output logic [15:0] pc,
  output logic [7:0]  ir,
  output logic [15:0] operand,
  output logic [7:0]  mem_operand,
  output logic        exec_strobe,
  output logic        sync
);

  typedef enum logic [2:0] {
    RST_LO  = 3'd0,
    RST_HI  = 3'd1,
    FETCH   = 3'd2,
    OPER_LO = 3'd3,
    OPER_HI = 3'd4,
    MEM_RD  = 3'd5,
    EXEC    = 3'd6
  } state_t;

  localparam logic [1:0] MODE_IMPL = 2'd0;
  localparam logic [1:0] MODE_IMM  = 2'd1;
  localparam logic [1:0] MODE_ZP   = 2'd2;
  localparam logic [1:0] MODE_ABS  = 2'd3;

  // High byte of the vector; the add truncates to 16 bits, so FFFF wraps to 0000.
  localparam logic [15:0] RESET_VECTOR_HI = RESET_VECTOR + 16'd1;

  state_t      r_state;
  state_t      w_state_next;
  logic [15:0] r_pc;
  logic [7:0]  r_ir;
  logic [15:0] r_operand;
  logic [7:0]  r_mem_operand;
  // Addressing mode captured with the opcode so MEM_RD addressing has no input path.
  logic [1:0]  r_mode;

  // State register; reset aborts any instruction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= RST_LO;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state selection; a stalled memory (rdy=0) freezes the sequence.
  always_comb begin
    w_state_next = r_state;
    if (rdy) begin
      case (r_state)
        RST_LO:  w_state_next = RST_HI;
        RST_HI:  w_state_next = FETCH;
        FETCH:   w_state_next = (addr_mode == MODE_IMPL) ? EXEC : OPER_LO;
        OPER_LO: begin
          case (r_mode)
            MODE_IMM: w_state_next = EXEC;
            MODE_ZP:  w_state_next = MEM_RD;
            MODE_ABS: w_state_next = OPER_HI;
            default:  w_state_next = EXEC;
          endcase
        end
        OPER_HI: w_state_next = MEM_RD;
        MEM_RD:  w_state_next = EXEC;
        EXEC:    w_state_next = FETCH;
        default: w_state_next = RST_LO;
      endcase
    end
  end

  // Bus-facing outputs decoded from state and registers only.
  always_comb begin
    addr        = r_pc;
    rd_en       = 1'b1;
    sync        = 1'b0;
    exec_strobe = 1'b0;
    case (r_state)
      RST_LO:  addr = RESET_VECTOR;
      RST_HI:  addr = RESET_VECTOR_HI;
      FETCH:   sync = 1'b1;
      MEM_RD:  addr = (r_mode == MODE_ZP) ? {8'h00, r_operand[7:0]} : r_operand;
      EXEC: begin
        rd_en       = 1'b0;
        exec_strobe = 1'b1;
      end
      default: addr = r_pc;
    endcase
  end

  // Datapath registers: PC, opcode, operand bytes and ALU memory operand.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pc          <= 16'h0000;
      r_ir          <= 8'h00;
      r_operand     <= 16'h0000;
      r_mem_operand <= 8'h00;
      r_mode        <= MODE_IMPL;
    end else if (rdy) begin
      case (r_state)
        RST_LO: r_pc[7:0]  <= data_in;
        RST_HI: r_pc[15:8] <= data_in;
        FETCH: begin
          r_ir   <= data_in;
          r_mode <= addr_mode;
          r_pc   <= r_pc + 16'd1;
        end
        OPER_LO: begin
          r_operand[7:0] <= data_in;
          r_pc           <= r_pc + 16'd1;
          if (r_mode == MODE_IMM) begin
            r_mem_operand <= data_in;
          end
        end
        OPER_HI: begin
          r_operand[15:8] <= data_in;
          r_pc            <= r_pc + 16'd1;
        end
        MEM_RD: r_mem_operand <= data_in;
        EXEC: begin
          if (pc_load) begin
            r_pc <= pc_load_val;
          end
        end
        default: r_pc <= r_pc;
      endcase
    end
  end

  assign pc          = r_pc;
  assign ir          = r_ir;
  assign operand     = r_operand;
  assign mem_operand = r_mem_operand;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic        rdy;
  logic [7:0]  data_in;
  logic [1:0]  addr_mode;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic [15:0] addr;
  logic        rd_en;
  logic [15:0] pc;
  logic [7:0]  ir;
  logic [15:0] operand;
  logic [7:0]  mem_operand;
  logic        exec_strobe;
  logic        sync;

  logic [7:0] mem [0:65535];
  int n_checks;
  int n_errors;

  cpu_sequencer #(.RESET_VECTOR(16'hFFFC)) dut (
    .clk(clk), .rst_n(rst_n), .rdy(rdy), .data_in(data_in),
    .addr_mode(addr_mode), .pc_load(pc_load), .pc_load_val(pc_load_val),
    .addr(addr), .rd_en(rd_en), .pc(pc), .ir(ir), .operand(operand),
    .mem_operand(mem_operand), .exec_strobe(exec_strobe), .sync(sync)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model and opcode decoder (from data_in during FETCH, from ir afterwards).
  function automatic logic [1:0] decode(input logic [7:0] op);
    case (op)
      8'hA9:   return 2'd1;
      8'hA5:   return 2'd2;
      8'hAD:   return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  assign data_in   = mem[addr];
  assign addr_mode = decode(sync ? data_in : ir);

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'hFFFC] = 8'h34; mem[16'hFFFD] = 8'h12;
    mem[16'h1234] = 8'hEA;
    mem[16'h1235] = 8'hA9; mem[16'h1236] = 8'h55;
    mem[16'h1237] = 8'hA5; mem[16'h1238] = 8'h80;
    mem[16'h1239] = 8'hAD; mem[16'h123A] = 8'h00; mem[16'h123B] = 8'h20;
    mem[16'h123C] = 8'hEA;
    mem[16'h4000] = 8'hEA;
    mem[16'h4001] = 8'hAD; mem[16'h4002] = 8'h00; mem[16'h4003] = 8'h20;
    mem[16'hFFFE] = 8'hA9; mem[16'hFFFF] = 8'h66;
    mem[16'h0000] = 8'hA5; mem[16'h0001] = 8'h80;
    mem[16'h0080] = 8'hC3;
    mem[16'h2000] = 8'h7E;

    rst_n = 1'b0; rdy = 1'b1; pc_load = 1'b0; pc_load_val = 16'h0000;
    step(); step();
    check("rst_addr", addr, 16'hFFFC);
    check("rst_rd_en", 16'(rd_en), 16'h1);
    check("rst_exec", 16'(exec_strobe), 16'h0);
    check("rst_sync", 16'(sync), 16'h0);
    check("rst_pc", pc, 16'h0000);

    rst_n = 1'b1;
    step();
    check("vec_hi_addr", addr, 16'hFFFD);
    step();
    check("fetch1_addr", addr, 16'h1234);
    check("fetch1_sync", 16'(sync), 16'h1);

    // Implied EA: 2 cycles
    step();
    check("impl_ir", 16'(ir), 16'h00EA);
    check("impl_exec", 16'(exec_strobe), 16'h1);
    check("impl_rd_en", 16'(rd_en), 16'h0);
    step();
    check("impl_next", addr, 16'h1235);

    // Immediate A9 55: 3 cycles
    step();
    check("imm_oper_addr", addr, 16'h1236);
    step();
    check("imm_exec", 16'(exec_strobe), 16'h1);
    check("imm_memop", 16'(mem_operand), 16'h0055);
    step();
    check("imm_next", addr, 16'h1237);
    check("imm_next_sync", 16'(sync), 16'h1);

    // Zero page A5 80: 4 cycles
    step();
    step();
    check("zp_memrd_addr", addr, 16'h0080);
    step();
    check("zp_memop", 16'(mem_operand), 16'h00C3);
    check("zp_exec", 16'(exec_strobe), 16'h1);
    step();
    check("zp_next", addr, 16'h1239);

    // Absolute AD 00 20: 5 cycles
    step();
    check("abs_lo_addr", addr, 16'h123A);
    step();
    check("abs_hi_addr", addr, 16'h123B);
    step();
    check("abs_memrd_addr", addr, 16'h2000);
    step();
    check("abs_memop", 16'(mem_operand), 16'h007E);
    check("abs_operand", operand, 16'h2000);
    step();
    check("abs_next", addr, 16'h123C);

    // pc_load in EXEC redirects the next fetch
    step();
    check("jmp_exec", 16'(exec_strobe), 16'h1);
    pc_load = 1'b1; pc_load_val = 16'h4000;
    step();
    pc_load = 1'b0;
    check("jmp_fetch", addr, 16'h4000);

    // pc_load during FETCH is ignored
    pc_load = 1'b1; pc_load_val = 16'h5555;
    step();
    pc_load = 1'b0;
    check("fetch_load_pc", pc, 16'h4001);
    step();
    check("fetch_load_next", addr, 16'h4001);

    // Absolute with a 3-cycle stall in OPER_HI
    step();
    step();
    check("stall_pre_addr", addr, 16'h4003);
    rdy = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("stall_addr", addr, 16'h4003);
      check("stall_pc", pc, 16'h4003);
      check("stall_rd_en", 16'(rd_en), 16'h1);
    end
    rdy = 1'b1;
    step();
    check("stall_memrd_addr", addr, 16'h2000);
    step();
    check("stall_memop", 16'(mem_operand), 16'h007E);

    // Stall in EXEC: strobe held, pc_load deferred until rdy
    pc_load = 1'b1; pc_load_val = 16'hFFFE;
    rdy = 1'b0;
    step();
    check("exec_stall_strobe", 16'(exec_strobe), 16'h1);
    check("exec_stall_pc", pc, 16'h4004);
    rdy = 1'b1;
    step();
    pc_load = 1'b0;
    check("wrap_fetch", addr, 16'hFFFE);

    // Immediate at FFFE wraps the PC to 0000
    step();
    check("wrap_oper_addr", addr, 16'hFFFF);
    step();
    check("wrap_memop", 16'(mem_operand), 16'h0066);
    check("wrap_pc", pc, 16'h0000);
    step();
    check("wrap_next", addr, 16'h0000);

    // Zero page, reset asserted during MEM_RD
    step();
    step();
    check("abort_memrd_addr", addr, 16'h0080);
    rst_n = 1'b0;
    #1;
    check("abort_addr", addr, 16'hFFFC);
    check("abort_exec", 16'(exec_strobe), 16'h0);
    check("abort_pc", pc, 16'h0000);
    check("abort_operand", operand, 16'h0000);
    check("abort_memop", 16'(mem_operand), 16'h0000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
